param_mem_ctrl: RTL and testbench
=================================

# param_mem_ctrl

Parametrised synchronous memory block with a request/acknowledge handshake, configurable wait states, byte-enabled writes and hardware clear on reset. It is the next-generation data memory for the datapath: generic data width, address width and depth, with a single outstanding transaction. Read data is held in a register with an explicit acknowledge instead of a tri-stated bus, and illegal addresses are reported.

## Interface
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- WAIT_CYC, 2, number of wait states per access; range 0..15.
- CLEAR_ON_RST, 1, when 1 every word is zeroed after reset; when 0 contents are left unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  transaction request; sampled only while rdy=1.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables for writes; be[i] controls wdata[8i+7:8i].
- rdy  out  1  block can accept a request this cycle.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid only with ack; 1 = address was ≥ DEPTH.
- rdata  out  DATA_W  read data register.
- init_busy  out  1  hardware clear in progress.

## Operation
- FSM states: CLEAR, IDLE, WAIT, DONE.
- Reset values: rdy=0, ack=0, err=0, rdata=0, init_busy=CLEAR_ON_RST. State is CLEAR if CLEAR_ON_RST=1, otherwise IDLE.
- CLEAR state:
  - Writes 0 to addresses 0..DEPTH-1, one word per clock, in ascending order.
  - init_busy=1 and rdy=0 throughout.
  - After the edge that writes word DEPTH-1, the FSM moves to IDLE and init_busy falls.
- IDLE state:
  - rdy=1.
  - At an edge where req=1, the block latches we, addr, wdata and be, loads the wait counter with WAIT_CYC, and moves to WAIT.
- WAIT state:
  - rdy=0.
  - Each edge with counter ≠ 0 decrements the counter.
  - The edge with counter = 0 performs the access and moves to DONE.
- Access rules:
  - Write with addr < DEPTH: each byte with be[i]=1 is updated; all other bytes are unchanged. be=0 changes nothing but still completes.
  - Read with addr < DEPTH: rdata ← mem[addr].
  - addr ≥ DEPTH: memory is not modified, rdata ← 0 for a read, and err=1 in DONE.
  - A write leaves rdata unchanged.
- DONE state:
  - ack=1 for exactly one cycle; err is valid in this cycle.
  - The next edge returns the FSM to IDLE.
- rdata holds its value until the next read completes.
- req while rdy=0 is ignored. Only one transaction is outstanding, so there are no read/write hazards.
- Reset asserted mid-transaction: the transaction is aborted, and a pending write is not performed. All outputs take their reset values immediately (asynchronously). If CLEAR_ON_RST=1, the clear restarts from address 0 after reset is released.

## Timing
- Request accepted at edge E0 → ack is high during the cycle after edge E0+WAIT_CYC+1.
- A write's memory update and a read's rdata load both happen at edge E0+WAIT_CYC+1, the same edge on which ack rises.
- rdy returns high after edge E0+WAIT_CYC+2. The earliest next accept is edge E0+WAIT_CYC+3.
- Clear duration: DEPTH cycles after reset release. The first request can be accepted at the edge after init_busy falls.
- No combinational path from any input to any output; all outputs are registered or decoded from the state.

## Test plan
- Reset release with DEPTH=256, CLEAR_ON_RST=1 → init_busy high for exactly 256 cycles, rdy=0 during the clear; afterwards, reads of addresses 0, 128 and 255 each return 0x0000.
- WAIT_CYC=2: write 0xBEEF to address 0x10 with be=2'b11, then read address 0x10 → ack pulses 3 cycles after each accept, rdata=0xBEEF, err=0.
- Byte-enable merge: write 0x1234 with be=11, then write 0xAB00 with be=10, then read → 0xAB34.
- DEPTH=200: write to address 0xF0, then read it → both complete with ack and err=1; the read returns 0x0000; address 0 is unchanged.
- Back-to-back requests with req held high, WAIT_CYC=0 → one transaction every 3 cycles, exactly one ack per transaction.
- Reset asserted during WAIT of a write to address 5 → ack never fires; after the clear, address 5 reads 0x0000.

Source files
------------

// File: rtl/param_mem_ctrl.sv
// Single-port data memory with req/ack handshake, programmable wait states,
// byte-enabled writes, out-of-range error reporting and optional clear after reset.
module param_mem_ctrl #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int DEPTH        = 256,
  parameter int WAIT_CYC     = 2,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                rdy,
  output logic                ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                init_busy
);

  // state | meaning
  // CLEAR | zeroing words 0..DEPTH-1, one per clock
  // IDLE  | ready to accept a request
  // WAIT  | counting wait states; access happens when counter reaches 0
  // DONE  | ack pulse, err valid

  localparam int NBYTE = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, DONE} stateT;

  localparam stateT RST_STATE = CLEAR_ON_RST ? CLEAR : IDLE;

  stateT state, nextState;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clrAddr;
  logic [ADDR_W-1:0] addrQ;
  logic              weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [NBYTE-1:0]  beQ;
  logic [3:0]        waitCnt;

  logic             accept;
  logic             access;
  logic             inRange;
  logic             clrLast;
  logic [IDX_W-1:0] memIdx;
  logic [IDX_W-1:0] clrIdx;

  // rdy is a register, so a request is only taken once rdy is actually visible
  assign accept  = (state == IDLE) && rdy && req;
  assign access  = (state == WAIT) && (waitCnt == 4'd0);
  assign inRange = {1'b0, addrQ} < (ADDR_W+1)'(DEPTH);
  assign clrLast = (clrAddr == ADDR_W'(DEPTH - 1));
  assign memIdx  = addrQ[IDX_W-1:0];
  assign clrIdx  = clrAddr[IDX_W-1:0];

  always_comb begin
    nextState = state;
    case (state)
      CLEAR:   if (clrLast) nextState = IDLE;
      IDLE:    if (accept) nextState = WAIT;
      WAIT:    if (waitCnt == 4'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      clrAddr   <= '0;
      addrQ     <= '0;
      weQ       <= 1'b0;
      wdataQ    <= '0;
      beQ       <= '0;
      waitCnt   <= 4'd0;
      rdy       <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      init_busy <= CLEAR_ON_RST;
    end else begin
      state     <= nextState;
      rdy       <= (nextState == IDLE);
      ack       <= (nextState == DONE);
      init_busy <= (nextState == CLEAR);
      err       <= access ? !inRange : 1'b0;

      if (state == CLEAR) clrAddr <= clrAddr + ADDR_W'(1);

      if (accept) begin
        weQ     <= we;
        addrQ   <= addr;
        wdataQ  <= wdata;
        beQ     <= be;
        waitCnt <= 4'(WAIT_CYC);
      end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end

      if (access && !weQ) rdata <= inRange ? mem[memIdx] : '0;
    end
  end

  // Storage has no reset; an asserted rst forces state away from WAIT so a
  // pending write can never land.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (access && weQ && inRange) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (beQ[i]) mem[memIdx][8*i +: 8] <= wdataQ[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_param_mem_ctrl.sv
// Directed bench for param_mem_ctrl: dut0 uses defaults (DEPTH=256, WAIT_CYC=2),
// dut1 uses DEPTH=200 and WAIT_CYC=0 for range errors and back-to-back requests.
module tb_param_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [7:0]  addr0 = '0;
  logic [15:0] wdata0 = '0;
  logic [1:0]  be0 = '0;
  logic        rdy0, ack0, err0, initBusy0;
  logic [15:0] rdata0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr1 = '0;
  logic [15:0] wdata1 = '0;
  logic [1:0]  be1 = '0;
  logic        rdy1, ack1, err1, initBusy1;
  logic [15:0] rdata1;

  int total = 0;
  int bad = 0;

  param_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(2), .CLEAR_ON_RST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0), .be(be0),
    .rdy(rdy0), .ack(ack0), .err(err0), .rdata(rdata0), .init_busy(initBusy0)
  );

  param_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYC(0), .CLEAR_ON_RST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1), .be(be1),
    .rdy(rdy1), .ack(ack1), .err(err1), .rdata(rdata1), .init_busy(initBusy1)
  );

  // Runs one transaction on dut0 (sel=0) or dut1 (sel=1); lat counts edges
  // from the accepting edge to the one after which ack is seen (-1 = never).
  task automatic txn(input int sel, input logic w, input logic [7:0] a, input logic [15:0] d,
                     input logic [1:0] b, output int lat, output logic [15:0] rd,
                     output logic e, output logic ackAfter);
    int k;
    k = 0; lat = -1; rd = '0; e = 1'b0; ackAfter = 1'b0;
    @(negedge clk);
    while (((sel == 0) ? rdy0 : rdy1) !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sel == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b; end
    else          begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b; end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (((sel == 0) ? ack0 : ack1) === 1'b1) begin
        lat = i;
        rd  = (sel == 0) ? rdata0 : rdata1;
        e   = (sel == 0) ? err0 : err1;
        break;
      end
    end
    @(posedge clk); #1;
    ackAfter = (sel == 0) ? ack0 : ack1;
  endtask

  task automatic test_reset;
    int busyLen0, busyLen1;
    logic rdyInClear;
    int lat; logic [15:0] rd; logic e, aa;
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h80; addrs[2] = 8'hFF;
    #1 rst = 1'b1;
    #2;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_rdy got %b want 0", rdy0); end
    total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", ack0); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err0); end
    total++; if (rdata0 !== 16'h0000) begin bad++; $display("FAIL reset_rdata got %h want 0000", rdata0); end
    total++; if (initBusy0 !== 1'b1) begin bad++; $display("FAIL reset_init_busy got %b want 1", initBusy0); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    busyLen0 = -1; busyLen1 = -1; rdyInClear = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (busyLen0 < 0 && initBusy0 === 1'b1 && rdy0 !== 1'b0) rdyInClear = 1'b1;
      if (busyLen0 < 0 && initBusy0 !== 1'b1) busyLen0 = k;
      if (busyLen1 < 0 && initBusy1 !== 1'b1) busyLen1 = k;
      if (busyLen0 >= 0 && busyLen1 >= 0) break;
    end
    total++; if (busyLen0 !== 256) begin bad++; $display("FAIL clear_len256 got %0d want 256", busyLen0); end
    total++; if (busyLen1 !== 200) begin bad++; $display("FAIL clear_len200 got %0d want 200", busyLen1); end
    total++; if (rdyInClear !== 1'b0) begin bad++; $display("FAIL rdy_in_clear got %b want 0", rdyInClear); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rdy_after_clear got %b want 1", rdy0); end
    for (int i = 0; i < 3; i++) begin
      txn(0, 1'b0, addrs[i], 16'h0000, 2'b00, lat, rd, e, aa);
      total++; if (rd !== 16'h0000 || lat !== 3) begin
        bad++; $display("FAIL clear_read addr=%h got %h lat %0d want 0000 lat 3", addrs[i], rd, lat);
      end
    end
  endtask

  task automatic test_write_read;
    int lat; logic [15:0] rd; logic e, aa;
    txn(0, 1'b1, 8'h10, 16'hBEEF, 2'b11, lat, rd, e, aa);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got %0d want 3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got %b want 0", e); end
    total++; if (aa !== 1'b0) begin bad++; $display("FAIL wr_ack_width got %b want 0", aa); end
    txn(0, 1'b0, 8'h10, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got %0d want 3", lat); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data got %h want beef", rd); end
    total++; if (e !== 1'b0 || aa !== 1'b0) begin bad++; $display("FAIL rd_err_ack got %b%b want 00", e, aa); end
  endtask

  task automatic test_byte_enable;
    int lat; logic [15:0] rd; logic e, aa;
    txn(0, 1'b1, 8'h20, 16'h1234, 2'b11, lat, rd, e, aa);
    txn(0, 1'b1, 8'h20, 16'hAB00, 2'b10, lat, rd, e, aa);
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'hAB34) begin bad++; $display("FAIL be_hi_merge got %h want ab34", rd); end
    txn(0, 1'b1, 8'h20, 16'hFFFF, 2'b00, lat, rd, e, aa);
    total++; if (lat !== 3) begin bad++; $display("FAIL be_none_completes got lat %0d want 3", lat); end
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'hAB34) begin bad++; $display("FAIL be_none_nochange got %h want ab34", rd); end
    txn(0, 1'b1, 8'h20, 16'h00CD, 2'b01, lat, rd, e, aa);
    txn(0, 1'b0, 8'h20, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'hABCD) begin bad++; $display("FAIL be_lo_merge got %h want abcd", rd); end
    txn(0, 1'b1, 8'h21, 16'h9999, 2'b11, lat, rd, e, aa);
    total++; if (rdata0 !== 16'hABCD) begin bad++; $display("FAIL rdata_hold_on_write got %h want abcd", rdata0); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [15:0] rd; logic e, aa;
    txn(1, 1'b1, 8'd199, 16'h1357, 2'b11, lat, rd, e, aa);
    total++; if (lat !== 1 || e !== 1'b0) begin bad++; $display("FAIL last_word_wr got lat %0d err %b want 1 0", lat, e); end
    txn(1, 1'b0, 8'd199, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h1357) begin bad++; $display("FAIL last_word_rd got %h want 1357", rd); end
    txn(1, 1'b1, 8'hF0, 16'h5A5A, 2'b11, lat, rd, e, aa);
    total++; if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL oor_wr got lat %0d err %b want 1 1", lat, e); end
    txn(1, 1'b0, 8'hF0, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h0000 || e !== 1'b1) begin bad++; $display("FAIL oor_rd got %h err %b want 0000 1", rd, e); end
    txn(1, 1'b0, 8'h00, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h0000 || e !== 1'b0) begin bad++; $display("FAIL oor_addr0 got %h err %b want 0000 0", rd, e); end
    txn(1, 1'b0, 8'd40, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL oor_alias got %h want 0000", rd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ackPat, rdyPat;
    int lat; logic [15:0] rd; logic e, aa;
    ackPat = '0; rdyPat = '0;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h03; wdata1 = 16'h7777; be1 = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      ackPat[k-1] = ack1;
      rdyPat[k-1] = rdy1;
      if (k == 12) req1 = 1'b0;
    end
    total++; if (ackPat !== 16'h0492) begin bad++; $display("FAIL b2b_ack_pattern got %h want 0492", ackPat); end
    total++; if (rdyPat !== 16'hF924) begin bad++; $display("FAIL b2b_rdy_pattern got %h want f924", rdyPat); end
    txn(1, 1'b0, 8'h03, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h7777) begin bad++; $display("FAIL b2b_readback got %h want 7777", rd); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] rd; logic e, aa;
    logic ackSeen;
    int doneK;
    txn(0, 1'b1, 8'h05, 16'h5555, 2'b11, lat, rd, e, aa);
    txn(0, 1'b1, 8'hFF, 16'h6666, 2'b11, lat, rd, e, aa);
    txn(0, 1'b0, 8'h05, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h5555) begin bad++; $display("FAIL pre_reset_rd got %h want 5555", rd); end
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 16'hA5A5; be0 = 2'b11;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++; if (initBusy0 !== 1'b1 || rdy0 !== 1'b0) begin
      bad++; $display("FAIL async_reset busy/rdy got %b%b want 10", initBusy0, rdy0);
    end
    total++; if (rdata0 !== 16'h0000) begin bad++; $display("FAIL async_reset_rdata got %h want 0000", rdata0); end
    ackSeen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack0 === 1'b1) ackSeen = 1'b1; end
    @(negedge clk); rst = 1'b0;
    doneK = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) ackSeen = 1'b1;
      if (initBusy0 !== 1'b1 && initBusy1 !== 1'b1) begin doneK = k; break; end
    end
    total++; if (ackSeen !== 1'b0) begin bad++; $display("FAIL abort_ack got %b want 0", ackSeen); end
    total++; if (doneK !== 256) begin bad++; $display("FAIL reclear_len got %0d want 256", doneK); end
    txn(0, 1'b0, 8'h05, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL abort_addr5 got %h want 0000", rd); end
    txn(0, 1'b0, 8'hFF, 16'h0000, 2'b00, lat, rd, e, aa);
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL reclear_addr255 got %h want 0000", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_byte_enable;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
